// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative multi-mode CORDIC.
//   mode_e    : per-transaction operating mode (rotation drives z to 0,
//               vectoring drives y to 0)
//   state_e   : controller states
//   atan_lut  : arctangent table scaled so that 2^(width-1) LSB = pi
package cordic_pkg;

  typedef enum logic {
    MODE_ROTATION  = 1'b0,
    MODE_VECTORING = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ITER = 1'b1
  } state_e;

  // round(atan(2^-i) * 2^(width-1) / pi). The table holds atan(2^-i)/pi with
  // 31 fractional bits. It is then rounded down to the requested angle width,
  // so one table serves every width from 4 to 16.
  function automatic int atan_lut(input int i, input int width);
    longint unsigned t;
    case (i)
      0:       t = 64'd536870912;
      1:       t = 64'd316933406;
      2:       t = 64'd167458907;
      3:       t = 64'd85004846;
      4:       t = 64'd42667331;
      5:       t = 64'd21354465;
      6:       t = 64'd10679884;
      7:       t = 64'd5340230;
      8:       t = 64'd2670176;
      9:       t = 64'd1335088;
      10:      t = 64'd667544;
      11:      t = 64'd333772;
      12:      t = 64'd166886;
      13:      t = 64'd83443;
      14:      t = 64'd41722;
      15:      t = 64'd20861;
      default: t = 64'd0;
    endcase
    t = (t + (64'd1 << (31 - width))) >> (32 - width);
    return int'(t);
  endfunction

endpackage

// File: rtl/cordic_micro_rotation.sv
// One CORDIC micro-rotation, purely combinational.
//   x_i, y_i  : current vector on the extended (guarded) datapath
//   z_i       : current angle, wraps modulo 2^ANGLE_W
//   iter_i    : iteration index i (shift amount and atan table index)
//   d_neg_i   : 1 selects direction d = -1, 0 selects d = +1
//   x_o, y_o  : x - d*(y>>>i), y + d*(x>>>i)
//   z_o       : z - d*atan(2^-i)
module cordic_micro_rotation
  import cordic_pkg::*;
#(
  parameter int DATA_W  = 10,
  parameter int ANGLE_W = 8
) (
  input  logic signed [DATA_W-1:0]  x_i,
  input  logic signed [DATA_W-1:0]  y_i,
  input  logic        [ANGLE_W-1:0] z_i,
  input  logic        [3:0]         iter_i,
  input  logic                      d_neg_i,
  output logic signed [DATA_W-1:0]  x_o,
  output logic signed [DATA_W-1:0]  y_o,
  output logic        [ANGLE_W-1:0] z_o
);

  logic signed [DATA_W-1:0]  x_shift;
  logic signed [DATA_W-1:0]  y_shift;
  logic        [ANGLE_W-1:0] atan_val;

  always_comb begin
    x_shift  = x_i >>> iter_i;
    y_shift  = y_i >>> iter_i;
    atan_val = ANGLE_W'(atan_lut(int'(iter_i), ANGLE_W));
    if (d_neg_i) begin
      x_o = x_i + y_shift;
      y_o = y_i - x_shift;
      z_o = z_i + atan_val;
    end else begin
      x_o = x_i - y_shift;
      y_o = y_i + x_shift;
      z_o = z_i - atan_val;
    end
  end

endmodule

// File: rtl/cordic_iterative_multimode.sv
// Iterative CORDIC: one sample at a time, one micro-rotation per clock.
// Supports rotation and vectoring modes, full-circle angles through
// quadrant pre-rotation, guard bits on x/y, and saturated x/y outputs.
//   clk_i, rst_i              : clock, asynchronous active-high reset
//   x_i, y_i, z_i, mode_i     : operands, sampled only on the accept edge
//   data_in_valid_strobe_i    : start request, honoured while ready_o = 1
//   ready_o                   : controller idle
//   x_o, y_o, z_o             : results, held until the next completion
//   data_out_valid_strobe_o   : one-cycle pulse when results update
module cordic_iterative_multimode
  import cordic_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ITERATIONS = 7,
  parameter int GUARD      = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [WIDTH-1:0] z_i,
  input  logic             mode_i,
  input  logic             data_in_valid_strobe_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] y_o,
  output logic [WIDTH-1:0] z_o,
  output logic             data_out_valid_strobe_o
);

  localparam int              DW        = WIDTH + GUARD;
  localparam logic [3:0]      LAST_ITER = 4'(ITERATIONS - 1);
  localparam logic [WIDTH-1:0] ANGLE_PI = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  state_e                  state_q;
  mode_e                   mode_q;
  logic [3:0]              count_q;
  logic signed [DW-1:0]    x_q, y_q;
  logic [WIDTH-1:0]        z_q;
  logic [WIDTH-1:0]        x_out_q, y_out_q, z_out_q;
  logic                    valid_q;

  logic signed [DW-1:0]    x_ext, y_ext, x_pre, y_pre;
  logic [WIDTH-1:0]        z_pre;
  logic                    pre_neg;
  logic                    d_neg;
  logic signed [DW-1:0]    x_d, y_d;
  logic [WIDTH-1:0]        z_d;

  // Clamp the guarded value to the output range. The value fits when every
  // bit above the output sign bit equals that sign bit.
  function automatic logic [WIDTH-1:0] saturate(input logic signed [DW-1:0] v);
    if (&v[DW-1:WIDTH-1] || ~|v[DW-1:WIDTH-1]) return v[WIDTH-1:0];
    else if (v[DW-1])                         return SAT_MIN;
    else                                      return SAT_MAX;
  endfunction

  // Pre-rotation by pi moves the vector into the right half-plane, where
  // the micro-rotations converge (their total reach is about +/-pi/2).
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    pre_neg = 1'b0;
    z_pre   = z_i;
    x_ext   = {{GUARD{x_i[WIDTH-1]}}, x_i};
    y_ext   = {{GUARD{y_i[WIDTH-1]}}, y_i};
    if (mode_e'(mode_i) == MODE_ROTATION) begin
      // The top two angle bits differ exactly when |z| > pi/2.
      pre_neg = z_i[WIDTH-1] ^ z_i[WIDTH-2];
      if (pre_neg) z_pre = z_i + ANGLE_PI;
    end else begin
      pre_neg = x_i[WIDTH-1];
      z_pre   = pre_neg ? ANGLE_PI : '0;
    end
    x_pre = pre_neg ? -x_ext : x_ext;
    y_pre = pre_neg ? -y_ext : y_ext;
  end

  // Rotation: d = +1 while z >= 0.  Vectoring: d = +1 while y < 0.
  assign d_neg = (mode_q == MODE_ROTATION) ? z_q[WIDTH-1] : ~y_q[DW-1];

  cordic_micro_rotation #(
    .DATA_W  (DW),
    .ANGLE_W (WIDTH)
  ) u_micro (
    .x_i     (x_q),
    .y_i     (y_q),
    .z_i     (z_q),
    .iter_i  (count_q),
    .d_neg_i (d_neg),
    .x_o     (x_d),
    .y_o     (y_d),
    .z_o     (z_d)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ROTATION;
      count_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
      z_out_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (data_in_valid_strobe_i) begin
            mode_q  <= mode_e'(mode_i);
            x_q     <= x_pre;
            y_q     <= y_pre;
            z_q     <= z_pre;
            count_q <= '0;
            state_q <= ST_ITER;
          end
        end
        ST_ITER: begin
          x_q <= x_d;
          y_q <= y_d;
          z_q <= z_d;
          if (count_q == LAST_ITER) begin
            count_q <= '0;
            state_q <= ST_IDLE;
            x_out_q <= saturate(x_d);
            y_out_q <= saturate(y_d);
            z_out_q <= z_d;
            valid_q <= 1'b1;
          end else begin
            count_q <= count_q + 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready_o                 = (state_q == ST_IDLE);
  assign x_o                     = x_out_q;
  assign y_o                     = y_out_q;
  assign z_o                     = z_out_q;
  assign data_out_valid_strobe_o = valid_q;

endmodule
